// File: rtl/rx_link_sync_ctrl_if.sv
// rx_link_sync_ctrl_if: bundle between the deserializer/8b10b decoder and the link-sync controller.
//   Decoder side -> controller: RxParallel_10 (raw 10b word, bit0='a'), RxParallel_8 (decoded byte),
//     RxDataK (K flag), decode_error, disparity_error.
//   Controller -> deserializer/upper layer: Bitslip, SyncStatus, RxValid, RxData, RxIsK, SyncLossCount.
//   master: the side feeding words in (PHY/decoder); slave: the controller.
interface rx_link_sync_ctrl_if;
  logic [9:0] RxParallel_10;
  logic [7:0] RxParallel_8;
  logic       RxDataK;
  logic       decode_error;
  logic       disparity_error;
  logic       Bitslip;
  logic       SyncStatus;
  logic       RxValid;
  logic [7:0] RxData;
  logic       RxIsK;
  logic [7:0] SyncLossCount;

  modport master (
    output RxParallel_10, RxParallel_8, RxDataK, decode_error, disparity_error,
    input  Bitslip, SyncStatus, RxValid, RxData, RxIsK, SyncLossCount
  );

  modport slave (
    input  RxParallel_10, RxParallel_8, RxDataK, decode_error, disparity_error,
    output Bitslip, SyncStatus, RxValid, RxData, RxIsK, SyncLossCount
  );
endinterface

// File: rtl/rx_link_sync_ctrl.sv
// rx_link_sync_ctrl: RX word-alignment / link-sync controller in front of an 8b/10b decoder.
//   Hunts for commas, pulses Bitslip until the word boundary locks, tracks decoder errors
//   while synced, and gates decoded bytes to the upper layer.
// Ports:
//   BitCLK_10 - word clock shared with the decoder
//   Reset     - asynchronous, active-high
//   bus       - rx_link_sync_ctrl_if.slave (raw/decoded words in, Bitslip/status/data out)
module rx_link_sync_ctrl #(
  parameter int unsigned COMMA_COUNT  = 3,
  parameter int unsigned ERR_LIMIT    = 4,
  parameter int unsigned GOOD_RUN     = 4,
  parameter int unsigned HUNT_TIMEOUT = 20,
  parameter int unsigned SLIP_WAIT    = 4
) (
  input  logic                 BitCLK_10,
  input  logic                 Reset,
  rx_link_sync_ctrl_if.slave   bus
);

  localparam int unsigned HUNT_W  = $clog2(HUNT_TIMEOUT);
  localparam int unsigned SLIP_W  = $clog2(SLIP_WAIT + 1);
  localparam int unsigned COMMA_W = $clog2(COMMA_COUNT + 1);
  localparam int unsigned ERR_W   = $clog2(ERR_LIMIT + 1);
  localparam int unsigned GOOD_W  = $clog2(GOOD_RUN + 1);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_SLIP = 2'd1;
  localparam logic [1:0] ST_ACQ  = 2'd2;
  localparam logic [1:0] ST_SYNC = 2'd3;

  logic [1:0]         r_state,     w_state_nxt;
  logic [HUNT_W-1:0]  r_hunt_cnt,  w_hunt_cnt_nxt;
  logic [SLIP_W-1:0]  r_slip_cnt,  w_slip_cnt_nxt;
  logic [COMMA_W-1:0] r_comma_cnt, w_comma_cnt_nxt;
  logic [ERR_W-1:0]   r_err_cnt,   w_err_cnt_nxt;
  logic [GOOD_W-1:0]  r_good_cnt,  w_good_cnt_nxt;
  logic [7:0]         r_loss_cnt,  w_loss_cnt_nxt;
  logic               r_bitslip,   w_bitslip_nxt;
  logic               r_valid,     w_valid_nxt;
  logic               r_comma_d;
  logic [1:0]         r_warm;
  logic               r_sync;
  logic [7:0]         r_data;
  logic               r_is_k;

  logic w_comma_raw, w_eval, w_bad, w_good_comma;
  logic w_unused_raw;

  // Comma is the 7-bit abcdeif pattern of either running disparity.
  assign w_comma_raw  = (bus.RxParallel_10[6:0] == 7'h7C) || (bus.RxParallel_10[6:0] == 7'h03);
  assign w_unused_raw = ^bus.RxParallel_10[9:7];

  // The decoder is never reset, so its first two outputs after Reset are meaningless.
  assign w_eval       = (r_warm == 2'd2);
  assign w_bad        = w_eval & (bus.decode_error | bus.disparity_error);
  assign w_good_comma = w_eval & r_comma_d & ~(bus.decode_error | bus.disparity_error);

  // Next-state and counter logic for the sync FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_hunt_cnt_nxt  = r_hunt_cnt;
    w_slip_cnt_nxt  = r_slip_cnt;
    w_comma_cnt_nxt = r_comma_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    w_good_cnt_nxt  = r_good_cnt;
    w_loss_cnt_nxt  = r_loss_cnt;
    w_bitslip_nxt   = 1'b0;
    w_valid_nxt     = 1'b0;
    if (w_eval) begin
      case (r_state)
        ST_HUNT: begin
          if (w_good_comma) begin
            w_state_nxt     = ST_ACQ;
            w_comma_cnt_nxt = COMMA_W'(1);
          end else if (r_hunt_cnt == HUNT_W'(HUNT_TIMEOUT - 1)) begin
            w_state_nxt    = ST_SLIP;
            w_bitslip_nxt  = 1'b1;
            w_slip_cnt_nxt = '0;
          end else begin
            w_hunt_cnt_nxt = r_hunt_cnt + HUNT_W'(1);
          end
        end
        // Dwell covers the pulse cycle plus SLIP_WAIT settling cycles, so pulses
        // are never closer than SLIP_WAIT+1 apart.
        ST_SLIP: begin
          if (r_slip_cnt == SLIP_W'(SLIP_WAIT)) begin
            w_state_nxt    = ST_HUNT;
            w_hunt_cnt_nxt = '0;
          end else begin
            w_slip_cnt_nxt = r_slip_cnt + SLIP_W'(1);
          end
        end
        ST_ACQ: begin
          if (w_bad) begin
            w_state_nxt    = ST_HUNT;
            w_hunt_cnt_nxt = '0;
          end else if (w_good_comma) begin
            if (r_comma_cnt == COMMA_W'(COMMA_COUNT - 1)) begin
              w_state_nxt    = ST_SYNC;
              w_err_cnt_nxt  = '0;
              w_good_cnt_nxt = '0;
            end else begin
              w_comma_cnt_nxt = r_comma_cnt + COMMA_W'(1);
            end
          end
        end
        ST_SYNC: begin
          // A bad word always wins over a completed good run.
          if (w_bad) begin
            w_good_cnt_nxt = '0;
            if (r_err_cnt == ERR_W'(ERR_LIMIT - 1)) begin
              w_state_nxt    = ST_HUNT;
              w_hunt_cnt_nxt = '0;
              w_err_cnt_nxt  = '0;
              if (r_loss_cnt != 8'hFF) w_loss_cnt_nxt = r_loss_cnt + 8'd1;
            end else begin
              w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
            end
          end else begin
            w_valid_nxt = 1'b1;
            if (r_good_cnt == GOOD_W'(GOOD_RUN - 1)) begin
              w_good_cnt_nxt = '0;
              if (r_err_cnt != '0) w_err_cnt_nxt = r_err_cnt - ERR_W'(1);
            end else begin
              w_good_cnt_nxt = r_good_cnt + GOOD_W'(1);
            end
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_HUNT;
      r_hunt_cnt  <= '0;
      r_slip_cnt  <= '0;
      r_comma_cnt <= '0;
      r_err_cnt   <= '0;
      r_good_cnt  <= '0;
      r_loss_cnt  <= '0;
      r_bitslip   <= 1'b0;
      r_valid     <= 1'b0;
      r_comma_d   <= 1'b0;
      r_warm      <= '0;
      r_sync      <= 1'b0;
      r_data      <= '0;
      r_is_k      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hunt_cnt  <= w_hunt_cnt_nxt;
      r_slip_cnt  <= w_slip_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_good_cnt  <= w_good_cnt_nxt;
      r_loss_cnt  <= w_loss_cnt_nxt;
      r_bitslip   <= w_bitslip_nxt;
      r_valid     <= w_valid_nxt;
      r_comma_d   <= w_comma_raw;
      r_warm      <= w_eval ? r_warm : r_warm + 2'd1;
      r_sync      <= (r_state == ST_SYNC);
      r_data      <= bus.RxParallel_8;
      r_is_k      <= bus.RxDataK;
    end
  end

  assign bus.Bitslip       = r_bitslip;
  assign bus.SyncStatus    = r_sync;
  assign bus.RxValid       = r_valid;
  assign bus.RxData        = r_data;
  assign bus.RxIsK         = r_is_k;
  assign bus.SyncLossCount = r_loss_cnt;

endmodule
